bp_dma_link_arbiter: RTL and testbench

- Wormhole-packet-aware round-robin arbiter.
- Shares one tile-side DMA ready_and link (the tile input of the DMA nd socket) among els_p requesters, e.g. L2 engine plus a DMA-capable accelerator.
- Holds the grant for a whole packet, decoded from the header length field, so flits of different packets never interleave.
- Sits between the requesters and the DMA socket tile_link_i, in the core clock domain.

---
 rtl/bp_dma_link_arbiter.sv | 153 +++++++++++++++
 tb/tb_bp_dma_link_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_dma_link_arbiter.sv
// Wormhole-packet-aware round-robin arbiter sharing one DMA ready_and link among els_p requesters.
// Define BP_DMA_LINK_ARB_PERF_EN to add saturating per-requester completed-packet counters.
`ifndef BSG_SAFE_CLOG2
`define BSG_SAFE_CLOG2(x) (((x) == 1) ? 1 : $clog2(x))
`endif

module bp_dma_link_arbiter #(
   parameter int flit_width_p = 64,
   parameter int len_width_p  = 4,
   parameter int len_offset_p = 8,
   parameter int els_p        = 2
) (
   input  logic                              clk_i,
   input  logic                              reset_n_i,
   input  logic [els_p-1:0]                  v_i,
   input  logic [els_p*flit_width_p-1:0]     data_i,
   output logic [els_p-1:0]                  ready_and_o,
   output logic                              v_o,
   output logic [flit_width_p-1:0]           data_o,
   input  logic                              ready_and_i,
   output logic [`BSG_SAFE_CLOG2(els_p)-1:0] grant_id_o,
   output logic                              busy_o,
   output logic [els_p*32-1:0]               pkt_count_o
);
   localparam int id_w_lp = `BSG_SAFE_CLOG2(els_p);

   typedef enum logic [0:0] {IDLE = 1'b0, BURST = 1'b1} state_e;

   state_e                 state_q, state_d;
   logic [len_width_p-1:0] cnt_q, cnt_d;
   logic [id_w_lp-1:0]     last_q, last_d;
   logic [id_w_lp-1:0]     gnt_q, gnt_d;
   logic [id_w_lp-1:0]     arb_id_s;
   logic [id_w_lp-1:0]     grant_id_s;
   logic                   arb_found_s;
   logic [len_width_p-1:0] len_s;
   logic                   xfer_s;

   // Circular priority search starting just after the previous packet's grantee.
   always_comb begin
      arb_found_s = 1'b0;
      arb_id_s    = '0;
      for (int k = 1; k <= els_p; k++) begin
         if (!arb_found_s && v_i[id_w_lp'((int'(last_q) + k) % els_p)]) begin
            arb_found_s = 1'b1;
            arb_id_s    = id_w_lp'((int'(last_q) + k) % els_p);
         end else begin
            arb_found_s = arb_found_s;
            arb_id_s    = arb_id_s;
         end
      end
   end

   // Grant is frozen for the whole packet; the selected flit passes through combinationally.
   always_comb begin
      grant_id_s  = (state_q == BURST) ? gnt_q : arb_id_s;
      v_o         = 1'b0;
      data_o      = '0;
      ready_and_o = '0;
      for (int i = 0; i < els_p; i++) begin
         if (grant_id_s == id_w_lp'(i)) begin
            v_o            = v_i[i];
            data_o         = data_i[i*flit_width_p +: flit_width_p];
            ready_and_o[i] = ready_and_i;
         end else begin
            ready_and_o[i] = 1'b0;
         end
      end
   end

   assign grant_id_o = grant_id_s;
   assign busy_o     = (state_q == BURST);
   assign len_s      = data_o[len_offset_p +: len_width_p];
   assign xfer_s     = v_o & ready_and_i;

   // Packet tracking: the header length sets how many body flits keep the grant.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      gnt_d   = gnt_q;
      case (state_q)
         IDLE: begin
            if (xfer_s && (len_s == '0)) begin
               last_d = grant_id_s;
            end else if (xfer_s) begin
               state_d = BURST;
               gnt_d   = grant_id_s;
               cnt_d   = len_s;
            end else begin
               state_d = IDLE;
            end
         end
         BURST: begin
            if (xfer_s && (cnt_q == len_width_p'(1))) begin
               state_d = IDLE;
               last_d  = gnt_q;
               cnt_d   = '0;
            end else if (xfer_s) begin
               cnt_d = cnt_q - len_width_p'(1);
            end else begin
               cnt_d = cnt_q;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State registers; last_q starts at the top index so requester 0 wins first.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         last_q  <= id_w_lp'(els_p - 1);
         gnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         gnt_q   <= gnt_d;
      end
   end

`ifdef BP_DMA_LINK_ARB_PERF_EN
   logic [els_p-1:0][31:0] pkt_cnt_q;
   logic                   pkt_done_s;

   assign pkt_done_s = xfer_s & (((state_q == IDLE) & (len_s == '0)) |
                                 ((state_q == BURST) & (cnt_q == len_width_p'(1))));

   // Saturating completed-packet counters, credited to the packet's grantee.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         pkt_cnt_q <= '0;
      end else begin
         for (int i = 0; i < els_p; i++) begin
            if (pkt_done_s && (grant_id_s == id_w_lp'(i)) && (pkt_cnt_q[i] != 32'hFFFF_FFFF)) begin
               pkt_cnt_q[i] <= pkt_cnt_q[i] + 32'd1;
            end else begin
               pkt_cnt_q[i] <= pkt_cnt_q[i];
            end
         end
      end
   end

   assign pkt_count_o = pkt_cnt_q;
`else
   assign pkt_count_o = '0;
`endif

endmodule

// File: tb/tb_bp_dma_link_arbiter.sv
// Self-checking bench for bp_dma_link_arbiter: directed scenarios plus randomized traffic
// compared against a packet-level reference model.
module tb_bp_dma_link_arbiter;
   localparam int W = 64;
   localparam int E = 2;

   logic           clk = 1'b0;
   logic           reset_n = 1'b0;
   logic [E-1:0]   v_i = '0;
   logic [E*W-1:0] data_i = '0;
   logic [E-1:0]   ready_and_o;
   logic           v_o;
   logic [W-1:0]   data_o;
   logic           ready_and_i = 1'b0;
   logic [0:0]     grant_id_o;
   logic           busy_o;
   logic [E*32-1:0] pkt_count_o;

   int n_checks = 0;
   int n_fail   = 0;

   // requester sources: current packet index, flit index within it, packet body length
   int src_len [E];
   int src_flit[E];
   int src_pkt [E];
   bit src_en  [E];
   bit src_rand;

   // packet-level reference model
   int           m_owner;
   int           m_left;
   int           m_last;
   int           m_pkts[E];
   logic         exp_v;
   logic [W-1:0] exp_data;
   logic [0:0]   exp_g;
   int           exp_gi;
   logic [E-1:0] exp_rdy;
   logic         exp_busy;
   logic [E-1:0] dut_hs;
   logic [E*32-1:0] exp_cnt;

   bp_dma_link_arbiter #(.flit_width_p(W), .len_width_p(4), .len_offset_p(8), .els_p(E)) dut (
      .clk_i(clk), .reset_n_i(reset_n), .v_i(v_i), .data_i(data_i),
      .ready_and_o(ready_and_o), .v_o(v_o), .data_o(data_o), .ready_and_i(ready_and_i),
      .grant_id_o(grant_id_o), .busy_o(busy_o), .pkt_count_o(pkt_count_o)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at time %0t", $time);
      $fatal(1);
   end

   function automatic logic [W-1:0] mk_flit(int r, int p, int f, int len);
      logic [W-1:0] d;
      d = {8'(r), 16'(p), 8'(f), 16'h5A5A, 4'(p), 4'(len), 8'(f)};
      if (f != 0) d[11:8] = 4'(p + f + 7);
      return d;
   endfunction

   function automatic int pick_len();
      return ($urandom_range(0, 9) == 0) ? 15 : int'($urandom_range(0, 3));
   endfunction

   task automatic drive();
      for (int r = 0; r < E; r++) begin
         v_i[r] = src_en[r];
         data_i[r*W +: W] = mk_flit(r, src_pkt[r], src_flit[r], src_len[r]);
      end
   endtask

   task automatic model_expect();
      int  g;
      bit  found;
      g = 0;
      found = 1'b0;
      if (m_owner >= 0) begin
         g = m_owner;
      end else begin
         for (int k = 1; k <= E; k++) begin
            if (!found && v_i[(m_last + k) % E]) begin
               found = 1'b1;
               g = (m_last + k) % E;
            end
         end
      end
      exp_gi   = g;
      exp_g    = 1'(g);
      exp_v    = v_i[g];
      exp_data = data_i[g*W +: W];
      exp_rdy  = '0;
      exp_rdy[g] = ready_and_i;
      exp_busy = (m_owner >= 0);
      dut_hs   = v_i & ready_and_o;
   endtask

   task automatic model_commit();
      if (exp_v && ready_and_i) begin
         if (m_owner < 0) begin
            if (exp_data[11:8] == 4'd0) begin
               m_last = exp_gi;
               m_pkts[exp_gi]++;
            end else begin
               m_owner = exp_gi;
               m_left  = int'(exp_data[11:8]);
            end
         end else begin
            m_left--;
            if (m_left == 0) begin
               m_last = m_owner;
               m_pkts[m_owner]++;
               m_owner = -1;
            end
         end
      end
   endtask

   task automatic cycle_end();
      @(posedge clk);
      #1;
      model_commit();
      for (int r = 0; r < E; r++) begin
         if (dut_hs[r]) begin
            if (src_flit[r] >= src_len[r]) begin
               src_flit[r] = 0;
               src_pkt[r]++;
               if (src_rand) src_len[r] = pick_len();
            end else begin
               src_flit[r]++;
            end
         end
      end
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      ready_and_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      m_owner = -1;
      m_left  = 0;
      m_last  = E - 1;
      src_rand = 1'b0;
      for (int r = 0; r < E; r++) begin
         m_pkts[r] = 0; src_flit[r] = 0; src_pkt[r] = 0; src_en[r] = 1'b0; src_len[r] = 0;
      end
   endtask

   task automatic calc_exp_cnt();
`ifdef BP_DMA_LINK_ARB_PERF_EN
      for (int r = 0; r < E; r++) exp_cnt[r*32 +: 32] = 32'(m_pkts[r]);
`else
      exp_cnt = '0;
`endif
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      ready_and_i = 1'b0;
      v_i = 2'b11;
      data_i = {$urandom, $urandom, $urandom, $urandom};
      #3;
      n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset.busy got=%b exp=0", busy_o); end
      n_checks++; if (ready_and_o !== 2'b00) begin n_fail++; $display("FAIL reset.ready got=%b exp=00", ready_and_o); end
      n_checks++; if (pkt_count_o !== '0) begin n_fail++; $display("FAIL reset.cnt got=%h exp=0", pkt_count_o); end
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(negedge clk);
      n_checks++; if (grant_id_o !== 1'b0) begin n_fail++; $display("FAIL reset.grant got=%b exp=0", grant_id_o); end
      n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset.busy_rel got=%b exp=0", busy_o); end
      n_checks++; if (v_o !== 1'b1) begin n_fail++; $display("FAIL reset.v_o got=%b exp=1", v_o); end
      v_i = 2'b00;
      #1;
      n_checks++; if (v_o !== 1'b0 || grant_id_o !== 1'b0) begin n_fail++; $display("FAIL reset.idle got v=%b g=%b exp v=0 g=0", v_o, grant_id_o); end
      @(posedge clk); #1;
   endtask

   task automatic test_contention();
      int er, p, f;
      do_reset();
      src_len[0] = 3; src_len[1] = 3; src_en[0] = 1'b1; src_en[1] = 1'b1;
      ready_and_i = 1'b1;
      for (int c = 0; c < 12; c++) begin
         drive();
         @(negedge clk);
         model_expect();
         er = (c / 4) % 2; p = c / 8; f = c % 4;
         n_checks++; if (grant_id_o !== 1'(er)) begin n_fail++; $display("FAIL contention.grant c=%0d got=%b exp=%0d", c, grant_id_o, er); end
         n_checks++; if (v_o !== 1'b1) begin n_fail++; $display("FAIL contention.v_o c=%0d got=%b exp=1", c, v_o); end
         n_checks++; if (data_o !== mk_flit(er, p, f, 3)) begin n_fail++; $display("FAIL contention.data c=%0d got=%h exp=%h", c, data_o, mk_flit(er, p, f, 3)); end
         n_checks++; if (busy_o !== (f != 0)) begin n_fail++; $display("FAIL contention.busy c=%0d got=%b exp=%b", c, busy_o, (f != 0)); end
         n_checks++; if (ready_and_o !== 2'(1 << er)) begin n_fail++; $display("FAIL contention.ready c=%0d got=%b", c, ready_and_o); end
         cycle_end();
      end
   endtask

   task automatic test_single_flit();
      do_reset();
      src_len[1] = 0; src_en[1] = 1'b1; src_en[0] = 1'b0;
      ready_and_i = 1'b1;
      for (int c = 0; c < 6; c++) begin
         drive();
         @(negedge clk);
         model_expect();
         n_checks++; if (grant_id_o !== 1'b1 || v_o !== 1'b1) begin n_fail++; $display("FAIL single.grant c=%0d got g=%b v=%b exp g=1 v=1", c, grant_id_o, v_o); end
         n_checks++; if (data_o !== mk_flit(1, c, 0, 0)) begin n_fail++; $display("FAIL single.data c=%0d got=%h exp=%h", c, data_o, mk_flit(1, c, 0, 0)); end
         n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL single.busy c=%0d got=%b exp=0", c, busy_o); end
         n_checks++; if (ready_and_o !== 2'b10) begin n_fail++; $display("FAIL single.ready c=%0d got=%b exp=10", c, ready_and_o); end
         cycle_end();
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      src_len[0] = 2; src_len[1] = 1; src_en[1] = 1'b1;
      for (int c = 0; c < 12; c++) begin
         ready_and_i = !(c >= 1 && c <= 5);
         src_en[0]   = !(c == 6 || c == 7);
         drive();
         @(negedge clk);
         model_expect();
         n_checks++; if (grant_id_o !== exp_g) begin n_fail++; $display("FAIL backpressure.grant c=%0d got=%b exp=%b", c, grant_id_o, exp_g); end
         n_checks++; if (v_o !== exp_v || data_o !== exp_data) begin n_fail++; $display("FAIL backpressure.flit c=%0d got v=%b d=%h exp v=%b d=%h", c, v_o, data_o, exp_v, exp_data); end
         n_checks++; if (busy_o !== exp_busy) begin n_fail++; $display("FAIL backpressure.busy c=%0d got=%b exp=%b", c, busy_o, exp_busy); end
         n_checks++; if (ready_and_o !== exp_rdy) begin n_fail++; $display("FAIL backpressure.ready c=%0d got=%b exp=%b", c, ready_and_o, exp_rdy); end
         n_checks++; if (grant_id_o !== ((c <= 9) ? 1'b0 : 1'b1)) begin n_fail++; $display("FAIL backpressure.hold c=%0d got=%b", c, grant_id_o); end
         cycle_end();
      end
   endtask

   task automatic test_max_len();
      do_reset();
      src_len[1] = 15; src_len[0] = 0; src_en[1] = 1'b1;
      ready_and_i = 1'b1;
      for (int c = 0; c < 17; c++) begin
         src_en[0] = (c >= 1);
         drive();
         @(negedge clk);
         model_expect();
         n_checks++; if (grant_id_o !== ((c < 16) ? 1'b1 : 1'b0)) begin n_fail++; $display("FAIL maxlen.grant c=%0d got=%b", c, grant_id_o); end
         n_checks++; if (busy_o !== (c >= 1 && c <= 15)) begin n_fail++; $display("FAIL maxlen.busy c=%0d got=%b", c, busy_o); end
         if (c < 16) begin
            n_checks++; if (data_o !== mk_flit(1, 0, c, 15)) begin n_fail++; $display("FAIL maxlen.data c=%0d got=%h exp=%h", c, data_o, mk_flit(1, 0, c, 15)); end
         end
         cycle_end();
      end
   endtask

   task automatic test_random();
      do_reset();
      src_rand = 1'b1;
      for (int r = 0; r < E; r++) src_len[r] = pick_len();
      for (int c = 0; c < 600; c++) begin
         for (int r = 0; r < E; r++) src_en[r] = ($urandom_range(0, 3) != 0);
         ready_and_i = ($urandom_range(0, 4) != 0);
         drive();
         @(negedge clk);
         model_expect();
         n_checks++; if (grant_id_o !== exp_g) begin n_fail++; $display("FAIL random.grant c=%0d got=%b exp=%b", c, grant_id_o, exp_g); end
         n_checks++; if (v_o !== exp_v || data_o !== exp_data) begin n_fail++; $display("FAIL random.flit c=%0d got v=%b d=%h exp v=%b d=%h", c, v_o, data_o, exp_v, exp_data); end
         n_checks++; if (busy_o !== exp_busy) begin n_fail++; $display("FAIL random.busy c=%0d got=%b exp=%b", c, busy_o, exp_busy); end
         n_checks++; if (ready_and_o !== exp_rdy) begin n_fail++; $display("FAIL random.ready c=%0d got=%b exp=%b", c, ready_and_o, exp_rdy); end
         cycle_end();
      end
      calc_exp_cnt();
      n_checks++; if (pkt_count_o !== exp_cnt) begin n_fail++; $display("FAIL random.count got=%h exp=%h", pkt_count_o, exp_cnt); end
   endtask

   task automatic test_perf();
      int cyc;
      do_reset();
      src_len[0] = 0; src_len[1] = 2;
      ready_and_i = 1'b1;
      cyc = 0;
      while ((src_pkt[0] < 10 || src_pkt[1] < 7) && cyc < 200) begin
         src_en[0] = (src_pkt[0] < 10);
         src_en[1] = (src_pkt[1] < 7);
         drive();
         @(negedge clk);
         model_expect();
         cycle_end();
         cyc++;
      end
      n_checks++; if (src_pkt[0] != 10 || src_pkt[1] != 7) begin n_fail++; $display("FAIL perf.timeout got=%0d/%0d exp=10/7", src_pkt[0], src_pkt[1]); end
      src_en[0] = 1'b0; src_en[1] = 1'b0;
      drive();
      @(negedge clk);
`ifdef BP_DMA_LINK_ARB_PERF_EN
      exp_cnt = {32'd7, 32'd10};
`else
      exp_cnt = '0;
`endif
      n_checks++; if (pkt_count_o !== exp_cnt) begin n_fail++; $display("FAIL perf.count got=%h exp=%h", pkt_count_o, exp_cnt); end
      @(posedge clk); #1;
      src_en[1] = 1'b1;
      drive();
      repeat (2) @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      n_checks++; if (pkt_count_o !== '0) begin n_fail++; $display("FAIL perf.reset_count got=%h exp=0", pkt_count_o); end
      n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL perf.reset_busy got=%b exp=0", busy_o); end
      @(posedge clk); #1;
      reset_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_contention();
      test_single_flit();
      test_backpressure();
      test_max_len();
      test_random();
      test_perf();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
